uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Synchronous serial receiver, the read-side end of the team's single-bit serial link.
- Accepts an asynchronous 1-wire line in the format: start bit 0, DATA_BITS data bits LSB-first, stop bit 1.
- Recovers each word and presents it on a parallel valid/ready port to the consuming logic.
- Sits at the chip-level serial input, between the pad and the command/data FIFO.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; even, >= 4
DATA_BITS, 8, data bits per frame; 5..9

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received word; stable while out_valid=1
out_valid  output  1  data_out holds an unconsumed word
out_ready  input  1  consumer accepts data_out this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: frame completed while previous word still unconsumed

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at the clk edge:
  - data_out=0, out_valid=0, frame_err=0, overrun=0.
  - Both synchronizer flops =1; FSM=IDLE; counters=0.
  - Applies mid-frame too: the partial frame is discarded with no output or flag.
- Input sync: rx passes through two flops (s1, s2); the FSM sees only s2.
- Timing reference: edge 0 is the first edge at which s1 captures rx=0. Let H=CLKS_PER_BIT/2 and C=CLKS_PER_BIT.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - s2=0 at edge 2 -> START; bit counter cleared.
- START:
  - Midpoint check at edge 2+H.
  - s2=0 -> DATA, bit index=0.
  - s2=1 -> IDLE (glitch rejected, no flags).
- DATA:
  - Data bit i is sampled at edge 2+H+(i+1)*C.
  - Each sample shifts into the MSB of the shift register, shifting right, so after DATA_BITS samples bit 0 is the first received bit.
  - After sampling bit DATA_BITS-1 -> STOP.
- STOP: stop bit sampled at edge 2+H+(DATA_BITS+1)*C.
  - s2=1 and out_valid=0 (or out_ready=1 this cycle): load data_out, out_valid=1 from the next cycle -> IDLE.
  - s2=1, out_valid=1, out_ready=0: new word dropped, data_out unchanged, overrun pulses 1 cycle -> IDLE.
  - s2=0: frame_err pulses 1 cycle, word dropped, out_valid unaffected -> BREAK.
- BREAK: wait until s2=1 -> IDLE. This prevents a held-low line from re-triggering frames.
- Handshake:
  - out_valid falls the cycle after out_valid&out_ready.
  - Simultaneous accept and new completion: out_valid stays 1 and data_out takes the new word.
  - data_out never changes while out_valid=1 without a handshake.
- Example latency, C=4, DATA_BITS=8: stop sample at edge 40; out_valid observed high after edge 40.
- Widths: C-counter is clog2(C) bits and wraps to 0 at each sample point. Bit index is clog2(DATA_BITS+1) bits.

Decomposition:
- Shared include/package holds:
  - FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4) as 3-bit localparams.
  - Default CLKS_PER_BIT and DATA_BITS.
  - Line idle level constant (1).
- One sub-module: sync_2ff, the 2-flop synchronizer. Ports: clk, rst, d, q. Reset value is set by parameter, =1 here.

Test Plan (C=4, DATA_BITS=8, rx=1 unless driven):
1. rst=1 for 2 cycles, then 0 -> data_out=8'h00, out_valid=0, frame_err=0, overrun=0; sync output=1.
2. Frame 8'hA5 sent, out_ready=0 -> out_valid=1 after edge 40, data_out=8'hA5. Then out_ready=1 for 1 cycle -> out_valid=0 next cycle.
3. rx low for 1 cycle only -> START aborts at midpoint; out_valid, frame_err, overrun all stay 0.
4. Frame 8'h3C with stop bit 0 -> frame_err 1-cycle pulse, out_valid=0. Line high 8 cycles, then frame 8'h01 -> out_valid=1, data_out=8'h01.
5. Frames 8'h11 then 8'h22 back-to-back, out_ready=0 -> data_out=8'h11, overrun pulses once at the second stop sample. Then out_ready=1 -> out_valid=0.
6. rst=1 for 1 cycle during data bit 3 of frame 8'h5A -> no output or flags. Next frame 8'hFF -> data_out=8'hFF, out_valid=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared constants for the serial receiver: default frame geometry,
//   the idle level of the line and the receive FSM state encodings.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  // An idle line sits high; a falling edge marks a start bit.
  localparam logic LINE_IDLE = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BREAK = ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer that brings an asynchronous level into the clk
//   domain. Both flops reset to RST_VAL so the output stays at a known
//   level through and just after reset.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   d    asynchronous input
//   q    synchronized output (second flop)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   Serial receiver: start bit 0, DATA_BITS data bits LSB-first, stop bit 1.
//   The recovered word is offered on a valid/ready port; a bad stop bit or a
//   word arriving while the previous one is still unconsumed is flagged with
//   a one-cycle pulse and the new word is dropped.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial line, idle high
//   data_out   received word, held while out_valid=1
//   out_valid  data_out holds an unconsumed word
//   out_ready  consumer takes data_out this cycle
//   frame_err  pulse: stop bit sampled low
//   overrun    pulse: word completed while previous word unconsumed
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Terminal counts: half a bit to reach the start-bit midpoint, a full bit
  // between later sample points.
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s2;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s2)
  );

  // New bits enter at the MSB so the first received bit ends up in bit 0.
  assign shift_d = {rx_s2, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (rx_s2 == 1'b0) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == HALF_TC) begin
            cnt_q <= '0;
            bit_q <= '0;
            // A line that is high again at mid-start was only a glitch.
            state_q <= (rx_s2 == 1'b0) ? S_DATA : S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_TC) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bit_q == LAST_BIT) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == BIT_TC) begin
            cnt_q <= '0;
            if (rx_s2 == 1'b1) begin
              // An accept in this same cycle frees the holding register,
              // so the new word can replace the consumed one directly.
              if (!valid_q || out_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                ovr_q <= 1'b1;
              end
              state_q <= S_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot spawn a stream of bogus frames.
          cnt_q <= '0;
          if (rx_s2 == 1'b1) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed frames into uart_rx (4 clocks per bit, 8 data bits). Expected
//   words go into a queue when a frame is sent; a monitor pops and compares
//   each time the receiver presents a new word, and tallies flag pulses.
module tb_uart_rx;

  localparam int C  = 4;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          out_ready = 1'b0;
  logic [DB-1:0] data_out;
  logic          out_valid;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DB-1:0] exp_q[$];
  int            fe_seen = 0;
  int            ovr_seen = 0;
  int            exp_fe = 0;
  int            exp_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor, sampling on the falling edge.
  logic          pv = 1'b0;
  logic          phs = 1'b0;
  logic          pfe = 1'b0;
  logic          povr = 1'b0;
  logic [DB-1:0] pd = '0;

  always @(negedge clk) begin
    if (out_valid && (!pv || phs)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL word: got unexpected data_out %0h, expected no word", data_out);
      end else begin
        check("word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end else if (out_valid && pv && !phs) begin
      check("hold", {24'd0, data_out}, {24'd0, pd});
    end
    if (frame_err) begin
      fe_seen++;
      if (pfe) check("ferr_width", 32'd2, 32'd1);
    end
    if (overrun) begin
      ovr_seen++;
      if (povr) check("ovr_width", 32'd2, 32'd1);
    end
    pv   = out_valid;
    phs  = out_valid && out_ready;
    pfe  = frame_err;
    povr = overrun;
    pd   = data_out;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one cycle before the stop-bit sample edge.
  task automatic send(input logic [DB-1:0] d, input logic stop);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      tick(C);
    end
    rx = stop;
    tick(C);
    rx = 1'b1;
  endtask

  initial begin
    logic [DB-1:0] w;

    // 1: reset
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t1_data", {24'd0, data_out}, 32'h0);
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_ferr", {31'd0, frame_err}, 32'd0);
    check("t1_ovr", {31'd0, overrun}, 32'd0);
    check("t1_sync", {31'd0, dut.u_sync.q}, 32'd1);

    // 2: one frame, latency and handshake
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    check("t2_valid_pre", {31'd0, out_valid}, 32'd0);
    tick(1);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_data", {24'd0, data_out}, 32'hA5);
    tick(3);
    check("t2_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("t2_valid_drop", {31'd0, out_valid}, 32'd0);

    // 3: one-cycle glitch
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("t3_valid", {31'd0, out_valid}, 32'd0);
    check("t3_ferr_cnt", fe_seen, 0);
    check("t3_ovr_cnt", ovr_seen, 0);

    // 4: bad stop bit, then recovery
    send(8'h3C, 1'b0);
    tick(1);
    exp_fe++;
    check("t4_ferr", {31'd0, frame_err}, 32'd1);
    tick(1);
    check("t4_ferr_off", {31'd0, frame_err}, 32'd0);
    check("t4_valid", {31'd0, out_valid}, 32'd0);
    tick(8);
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1);
    tick(1);
    check("t4_valid2", {31'd0, out_valid}, 32'd1);
    check("t4_data2", {24'd0, data_out}, 32'h01);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;

    // 5: overrun
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    tick(1);
    exp_ovr++;
    check("t5_ovr", {31'd0, overrun}, 32'd1);
    check("t5_data", {24'd0, data_out}, 32'h11);
    tick(1);
    check("t5_ovr_off", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("t5_valid_drop", {31'd0, out_valid}, 32'd0);

    // 6: reset in the middle of data bit 3, sender aborts the frame
    w = 8'h5A;
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      rx = w[i];
      tick(C);
    end
    rx = w[3];
    tick(2);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(60);
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_ferr_cnt", fe_seen, exp_fe);
    check("t6_ovr_cnt", ovr_seen, exp_ovr);
    exp_q.push_back(8'hFF);
    send(8'hFF, 1'b1);
    tick(1);
    check("t6_valid2", {31'd0, out_valid}, 32'd1);
    check("t6_data2", {24'd0, data_out}, 32'hFF);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;

    tick(5);
    check("end_queue", exp_q.size(), 0);
    check("end_ferr_cnt", fe_seen, exp_fe);
    check("end_ovr_cnt", ovr_seen, exp_ovr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
